// File: rtl/fast_frame_ctrl.sv
// Frame sequencer for the FAST/NMS datapath: unpacks AXI-Stream pixel words,
// drains the pipeline, buffers corner coordinates and streams them back out.
module fast_frame_ctrl #(
    parameter int COL_NUM      = 640,
    parameter int ROW_NUM      = 480,
    parameter int FLUSH_CYCLES = 1300,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  pix_data,
    output logic        pix_ce,
    input  logic        iscorner,
    input  logic [9:0]  x_coord,
    input  logic [9:0]  y_coord,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [15:0] corner_cnt,
    output logic        overflow,
    output logic        err_early_last
);
    localparam int TOTAL = COL_NUM * ROW_NUM;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int FW    = $clog2(FLUSH_CYCLES + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FEED, FLUSH, TERM, DONE} state_t;

    state_t        state;
    logic [31:0]   hold_data;
    logic [3:0]    hold_keep;
    logic          hold_last;
    logic [CW-1:0] acc_cnt;
    logic [CW-1:0] emit_cnt;
    logic [FW-1:0] flush_cnt;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    logic [3:0]    keep_rest;
    logic          emit;
    logic          accept;
    logic [CW-1:0] room;
    logic [3:0]    trim_keep;
    logic [2:0]    trim_n;
    logic [7:0]    sel_byte;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          capture;
    logic          push;

    // Unemitted-byte mask minus its lowest bit; zero means at most one byte remains.
    assign keep_rest     = hold_keep & (hold_keep - 4'd1);
    assign emit          = (state == FEED) && (hold_keep != 4'd0);
    assign s_axis_tready = (state == FEED) && (keep_rest == 4'd0) && (acc_cnt < TOTAL_C) && !hold_last;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // Keep only as many kept bytes as still fit in the frame, LSB-first.
    always_comb begin
        room      = TOTAL_C - acc_cnt;
        trim_keep = 4'd0;
        trim_n    = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (s_axis_tkeep[i] && (CW'(trim_n) < room)) begin
                trim_keep[i] = 1'b1;
                trim_n       = trim_n + 3'd1;
            end
        end
    end

    always_comb begin
        sel_byte = 8'h00;
        for (int i = 3; i >= 0; i--) begin
            if (hold_keep[i]) sel_byte = hold_data[8*i +: 8];
        end
    end

    assign pix_data = emit ? sel_byte : 8'h00;
    assign pix_ce   = emit || (state == FLUSH);
    assign busy     = (state == FEED) || (state == FLUSH) || (state == TERM);
    assign done     = (state == DONE);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && m_axis_tready;
    assign capture    = pix_ce && iscorner;
    assign push       = capture && (!fifo_full || pop);

    // Terminator only once the FIFO is drained, so corner words never reorder past it.
    assign m_axis_tvalid = !fifo_empty || (state == TERM);
    assign m_axis_tlast  = fifo_empty && (state == TERM);
    assign m_axis_tkeep  = {4{m_axis_tvalid}};
    assign m_axis_tdata  = !fifo_empty ? mem[rd_ptr[AW-1:0]] :
                           (state == TERM) ? 32'hFFFF_FFFF : 32'h0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {6'b0, y_coord, 6'b0, x_coord};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            hold_data      <= 32'h0;
            hold_keep      <= 4'd0;
            hold_last      <= 1'b0;
            acc_cnt        <= '0;
            emit_cnt       <= '0;
            flush_cnt      <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            corner_cnt     <= 16'h0;
            overflow       <= 1'b0;
            err_early_last <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            if (capture && corner_cnt != 16'hFFFF) corner_cnt <= corner_cnt + 16'd1;
            if (capture && fifo_full && !pop) overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= FEED;
                        hold_keep      <= 4'd0;
                        hold_last      <= 1'b0;
                        acc_cnt        <= '0;
                        emit_cnt       <= '0;
                        flush_cnt      <= '0;
                        wr_ptr         <= '0;
                        rd_ptr         <= '0;
                        corner_cnt     <= 16'h0;
                        overflow       <= 1'b0;
                        err_early_last <= 1'b0;
                    end
                end
                FEED: begin
                    if (accept) begin
                        hold_data <= s_axis_tdata;
                        hold_keep <= trim_keep;
                        hold_last <= s_axis_tlast;
                        acc_cnt   <= acc_cnt + CW'(trim_n);
                    end else begin
                        hold_keep <= keep_rest;
                    end
                    if (emit) emit_cnt <= emit_cnt + CW'(1);
                    if (emit && emit_cnt == TOTAL_C - CW'(1)) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                    end else if (hold_last && keep_rest == 4'd0) begin
                        state          <= FLUSH;
                        flush_cnt      <= '0;
                        err_early_last <= 1'b1;
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + FW'(1);
                    if (flush_cnt == FLUSH_LAST) state <= TERM;
                end
                TERM: begin
                    if (fifo_empty && m_axis_tready) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fast_frame_ctrl.md
# fast_frame_ctrl

Frame-level controller that sequences the FAST/NMS corner-detection datapath for one image per `start` pulse. It accepts 32-bit pixel words from the DMA MM2S AXI-Stream and unpacks them into one pixel per cycle with the datapath clock-enable. It drains the pipeline after the last pixel and buffers detected corner coordinates in a FIFO. It returns them to the DMA S2MM stream as packed words, closing the frame with a `tlast` terminator word.

## Interface
- `COL_NUM`, 640, pixels per row
- `ROW_NUM`, 480, rows per frame
- `FLUSH_CYCLES`, 1300, `pix_ce` cycles issued after the last pixel to drain line buffers, NMS and data delay
- `FIFO_DEPTH`, 16, corner FIFO entries (power of 2, ≥2)

Ports:
- `clk` in 1: single clock
- `rst` in 1: reset, asynchronous, active-low
- `start` in 1: frame start pulse; ignored while `busy`=1
- `busy` out 1: high from the cycle after accepted `start` until `done`
- `done` out 1: one-cycle pulse when the terminator handshake completes
- `s_axis_tdata` in 32, `s_axis_tkeep` in 4, `s_axis_tlast` in 1, `s_axis_tvalid` in 1, `s_axis_tready` out 1: pixel input stream
- `pix_data` out 8: pixel to datapath `data_in`
- `pix_ce` out 1: datapath `ce`
- `iscorner` in 1, `x_coord` in 10, `y_coord` in 10: NMS output
- `m_axis_tdata` out 32, `m_axis_tkeep` out 4, `m_axis_tlast` out 1, `m_axis_tvalid` out 1, `m_axis_tready` in 1: corner output stream
- `corner_cnt` out 16: corners captured this frame, saturating at 16'hFFFF
- `overflow` out 1: sticky per frame; a corner was dropped because the FIFO was full
- `err_early_last` out 1: sticky per frame; `s_axis_tlast` arrived before COL_NUM*ROW_NUM pixels

## Operation
- The FSM has five states: IDLE, FEED, FLUSH, TERM, DONE.
- IDLE → FEED on `start`. The transition clears `corner_cnt`, `overflow`, `err_early_last`, the pixel counters and the FIFO.
- FEED:
  - A word is accepted on `s_axis_tvalid && s_axis_tready`.
  - Bytes with `tkeep` bit set are emitted LSB-first, one per cycle, on `pix_data` with `pix_ce`=1. Bytes with a clear `tkeep` bit are skipped.
  - `s_axis_tready` = FEED && (unemitted bytes in holding register ≤ 1) && (accepted-pixel count < COL_NUM*ROW_NUM).
  - Back-to-back valid words therefore give 1 pixel/cycle with no bubbles.
  - Kept bytes beyond the frame total within the final word are discarded.
  - Move to FLUSH when emitted pixels = COL_NUM*ROW_NUM.
  - Also move to FLUSH when the holding register empties after a word with `tlast`=1 while emitted pixels are short of the total. In that case set `err_early_last`.
- FLUSH: `pix_ce`=1 and `pix_data`=0 for exactly FLUSH_CYCLES cycles, then go to TERM.
- Corner capture, in FEED and FLUSH:
  - When `pix_ce && iscorner`, push {6'b0, y_coord, 6'b0, x_coord}.
  - If the FIFO is full, drop the corner and set `overflow`.
  - `corner_cnt` increments on every capture, dropped or not.
- Output stream:
  - The FIFO head drives `m_axis_tdata` whenever the FIFO is non-empty, in all states.
  - `m_axis_tkeep`=4'hF whenever `m_axis_tvalid`=1.
  - `m_axis_tlast`=0 for corner words.
- TERM: once the FIFO is empty, present 32'hFFFF_FFFF with `tlast`=1. This value cannot collide with a corner word. On handshake go to DONE.
- DONE: pulse `done`, return to IDLE.
- AXI rule: once `m_axis_tvalid` rises, `tdata`, `tlast` and `tvalid` hold stable until `m_axis_tready`=1.
- Reset:
  - Asserting `rst`=0 at any time, mid-frame included, forces IDLE and empties the FIFO.
  - All outputs go to 0: `s_axis_tready`, `pix_ce`, `pix_data`, `m_axis_*`, `busy`, `done`, `corner_cnt`, `overflow`, `err_early_last`.

## Timing
- `start` at cycle t: `busy`=1 and `s_axis_tready`=1 at t+1.
- Word accepted at cycle a: byte0 on `pix_data` with `pix_ce` at a+1, byte1 at a+2, and so on. The next word can be accepted at the cycle its predecessor's last byte is emitted.
- FLUSH begins the cycle after the last pixel is emitted, so `pix_ce` stays continuous.
- FIFO timing:
  - A push at cycle c makes the word visible on `m_axis_tvalid` at c+1.
  - Simultaneous push and pop when full is allowed and is not an overflow.
  - Pop and push pointers wrap modulo FIFO_DEPTH.
- The terminator appears on the cycle after the last corner word handshakes, or at the first TERM cycle if the FIFO is already empty. `done` asserts the cycle after the terminator handshake. `busy` falls together with `done`.
- `overflow` and `err_early_last` stay readable after `done` until the next accepted `start`.

## Test plan
Bench parameters: COL_NUM=8, ROW_NUM=2, FLUSH_CYCLES=5, FIFO_DEPTH=4.
- Normal frame:
  - Stimulus: 4 words 0x03020100 … 0x0F0E0D0C, tkeep=F, tlast on word 4, no corners, tready=1.
  - Required: `pix_data` 0x00..0x0F on 16 consecutive `pix_ce` cycles, then 5 zero cycles, then the single word FFFFFFFF with tlast=1, then a `done` pulse; `corner_cnt`=0.
- Corners:
  - Stimulus: `iscorner` with (x=3,y=1) during FEED and (x=5,y=2) during FLUSH.
  - Required: m_axis words 0x00010003, 0x00020005, then the terminator; `corner_cnt`=2.
- Backpressure/overflow:
  - Stimulus: `m_axis_tready`=0 while 6 corners are captured, then 1.
  - Required: 4 corner words drained in order, stable while stalled; `overflow`=1; `corner_cnt`=6.
- Early tlast:
  - Stimulus: tlast on word 2.
  - Required: 8 pixels, then 5 flush cycles, then the terminator; `err_early_last`=1.
- Partial keep:
  - Stimulus: word 1 with tkeep=4'b0011 and data 0xAABB2211, then 4 more full words.
  - Required: 0x11, 0x22 emitted, then the next word's bytes follow immediately; 16 pixels total, with the excess bytes of the last word discarded.
- Reset:
  - Stimulus: `rst`=0 mid-FEED with 2 corners in the FIFO.
  - Required: all outputs 0 at once, FIFO empty; a new `start` runs a clean frame.
